// File: rtl/e_muldiv.sv
// e_muldiv: execute-stage multiply/divide unit with architectural HI/LO.
// MULT/MULTU/DIV/DIVU compute their result at acceptance, then hold busy for
// a fixed number of cycles before committing it; MTHI/MTLO write immediately.
module e_muldiv #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  op,
   input  logic        flush,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W_RAW  = $clog2(MAX_CYCLES + 1);
   localparam int unsigned CNT_W      = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

   localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   // 64-bit product; operands are sign- or zero-extended so the low 64 bits
   // of a 64x64 multiply are the correct signed or unsigned result.
   function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
      logic [63:0] ax;
      logic [63:0] bx;
      ax = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      bx = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      return ax * bx;
   endfunction

   // {remainder, quotient}. Signed division goes through magnitudes, which
   // truncates toward zero, gives the remainder the dividend's sign, and
   // yields 0x80000000 / 0 for the 0x80000000 / -1 overflow case. A zero
   // divisor returns zeros; the caller never commits that result.
   function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
      logic        a_neg;
      logic        b_neg;
      logic [31:0] a_mag;
      logic [31:0] b_mag;
      logic [31:0] q_mag;
      logic [31:0] r_mag;
      logic [31:0] quo;
      logic [31:0] rem;
      a_neg = sgn & a[31];
      b_neg = sgn & b[31];
      a_mag = a_neg ? (32'd0 - a) : a;
      b_mag = b_neg ? (32'd0 - b) : b;
      if (b_mag == 32'd0) begin
         q_mag = 32'd0;
         r_mag = 32'd0;
      end else begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem = a_neg ? (32'd0 - r_mag) : r_mag;
      return {rem, quo};
   endfunction

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;
   logic [63:0]      res_q;
   logic [63:0]      res_d;
   logic             wr_pending_q;
   logic             wr_pending_d;
   logic [CNT_W-1:0] cnt_load_s;
   logic [63:0]      mul_res_s;
   logic [63:0]      div_res_s;
   logic             is_mt_s;

   // start goes to the hazard unit unregistered; it ignores busy on purpose.
   always_comb begin
      start = 1'b0;
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start = ~flush;
         default:                            start = 1'b0;
      endcase
   end

   // Result, write-enable and cycle count that an accepted op would latch.
   always_comb begin
      mul_res_s    = mul64(rs_data, rt_data, op == OP_MULT);
      div_res_s    = div64(rs_data, rt_data, op == OP_DIV);
      res_d        = res_q;
      wr_pending_d = wr_pending_q;
      cnt_load_s   = '0;
      is_mt_s      = 1'b0;
      case (op)
         OP_MULT, OP_MULTU: begin
            res_d        = mul_res_s;
            wr_pending_d = 1'b1;
            cnt_load_s   = MULT_N;
         end
         OP_DIV, OP_DIVU: begin
            res_d        = div_res_s;
            wr_pending_d = (rt_data != 32'd0);
            cnt_load_s   = DIV_N;
         end
         OP_MTHI, OP_MTLO: begin
            is_mt_s = ~flush;
         end
         default: begin
            is_mt_s = 1'b0;
         end
      endcase
   end

   // Control FSM plus HI/LO: accept in IDLE, count down in RUN, commit at the end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
         res_q        <= 64'd0;
         wr_pending_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q      <= S_RUN;
                  cnt_q        <= cnt_load_s;
                  busy_q       <= 1'b1;
                  res_q        <= res_d;
                  wr_pending_q <= wr_pending_d;
               end else if (is_mt_s && (op == OP_MTHI)) begin
                  hi_q <= rs_data;
               end else if (is_mt_s && (op == OP_MTLO)) begin
                  lo_q <= rs_data;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  if (wr_pending_q) begin
                     hi_q <= res_q[63:32];
                     lo_q <= res_q[31:0];
                  end else begin
                     hi_q <= hi_q;
                  end
               end else begin
                  busy_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/e_muldiv.md
# e_muldiv

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register and takes the operation code and the already-forwarded rs/rt operands of the instruction currently in E. It runs multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO, and holds the architectural HI/LO registers. Its start/busy outputs feed the hazard unit so that later HI/LO instructions stall in D.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk)
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- flush  input  1  instruction in E is cancelled; suppresses every op this cycle
- rs_data  input  32  forwarded rs operand
- rt_data  input  32  forwarded rt operand
- start  output  1  combinational: op ∈ {MULT,MULTU,DIV,DIVU} and !flush
- busy  output  1  registered: a multi-cycle operation is in progress
- hi  output  32  registered HI
- lo  output  32  registered LO

## Operation
- State: IDLE / RUN. Internal down-counter cnt (4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES)), latched result pair (res_hi, res_lo), latched write-enable wr_pending.
- IDLE, accepted op (op valid, !flush, !busy):
  - MULT: {res_hi,res_lo} = signed 64-bit rs×rt.
  - MULTU: the unsigned 64-bit rs×rt.
  - DIV: res_lo = signed quotient, truncated toward zero; res_hi = remainder, sign of dividend (rs).
  - DIVU: unsigned quotient/remainder.
  - DIV with rs=0x80000000, rt=0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (rt=0): wr_pending=0; HI/LO keep old values; busy timing unchanged.
  - Otherwise wr_pending=1. cnt ← N (MULT_CYCLES or DIV_CYCLES); busy ← 1; go to RUN.
  - MTHI: hi ← rs_data. MTLO: lo ← rs_data. Written at this edge; no busy.
- RUN: cnt decrements every edge. At the edge where cnt==1: if wr_pending, hi ← res_hi and lo ← res_lo; busy ← 0; return to IDLE.
- Any op arriving while busy=1 is ignored; the hazard unit guarantees none arrives. The bench checks that it is ignored.
- flush=1 suppresses start and MTHI/MTLO in that cycle. flush does not abort an operation already in RUN.
- Operands are captured at acceptance. Later changes to rs_data/rt_data have no effect.
- hi/lo are only ever written by a completed mult/div (with wr_pending), by MTHI/MTLO, or by reset.

## Timing
- Reset (reset=0): busy=0, hi=0, lo=0, cnt=0, state IDLE, wr_pending=0. Takes effect immediately, including mid-operation; the operation in flight is discarded.
- start is combinational in the same cycle as op; it is never registered.
- Accept in cycle T. busy=1 in cycles T+1 … T+N. busy=0 and the new hi/lo are visible from cycle T+N+1.
- A new start is accepted in the cycle T+N+1 itself (back-to-back).
- MTHI/MTLO accepted in cycle T: the new value is visible on hi/lo in T+1.
- No output changes on a cycle with op=NONE in IDLE.

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 in cycle T -> start=1 in T; busy=1 in T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0 at T+6.
- DIVU rs=100, rt=7, then DIV rs=-7 (0xFFFFFFF9), rt=2 issued at T+11 -> after the first: lo=14, hi=2 at T+11. After the second: lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy=0 at T+22.
- MTHI rs=0x12345678, then DIV rt=0 -> hi=0x12345678 next cycle; busy high 10 cycles; hi/lo unchanged afterwards.
- MULTU with flush=1 -> start=0; busy stays 0; hi/lo unchanged. MTLO with flush=1 -> lo unchanged.
- MULT accepted, then MTLO and a DIV presented during busy -> both ignored; only the MULT result lands, at T+6.
- DIV in progress, then reset pulsed low for a partial cycle in RUN -> busy=0, hi=lo=0 immediately; no later write occurs.
